gf2_poly_divider: RTL and testbench

- Sequential GF(2) polynomial long divider; the inverse of the team's carry-less Karatsuba multipliers.
- Takes a (2N-1)-bit dividend (multiplier-output width) and an N-bit divisor.
- Returns quotient and remainder such that dividend = quotient*divisor XOR remainder, all arithmetic carry-less.
- Used for modular reduction of multiplier products and for self-checking multiplier paths.

---
 rtl/gf2_poly_divider_if.sv | 38 +++
 rtl/gf2_poly_divider.sv | 117 +++++++++++
 tb/tb_gf2_poly_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gf2_poly_divider_if.sv
// Request/result bundle for the GF(2) polynomial divider.
// The requester drives start and the operands; the divider returns status and results.
interface gf2_poly_divider_if #(
   parameter int unsigned N = 16
);

   logic             start;
   logic [2*N-2:0]   dividend;
   logic [N-1:0]     divisor;
   logic             busy;
   logic             done;
   logic [2*N-2:0]   quotient;
   logic [N-2:0]     remainder;
   logic             div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  busy,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output busy,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );

endinterface

// File: rtl/gf2_poly_divider.sv
// Sequential carry-less (GF(2)) polynomial long divider.
// One dividend bit position is examined per cycle, from x^(2N-2) down to x^0, so the
// latency is fixed at 2N cycles from start to done for any non-zero divisor.
module gf2_poly_divider #(
   parameter int unsigned N = 16
) (
   input logic               clk,
   input logic               rst_n,
   gf2_poly_divider_if.slave bus
);

   localparam int unsigned W  = 2 * N - 1;
   localparam int unsigned KW = $clog2(W);
   localparam int unsigned DW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [N-1:0]    dreg_q, dreg_d;
   logic [DW-1:0]   deg_q, deg_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    quot_q, quot_d;
   logic [N-2:0]    remain_q, remain_d;
   logic            dbz_q, dbz_d;

   logic [DW-1:0]   msb_idx;
   logic [KW-1:0]   shamt;
   logic [W-1:0]    dext;
   logic [W-1:0]    rem_step;

   // Degree of the incoming divisor (index of its highest set bit; 0 when divisor is 0).
   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (bus.divisor[i]) msb_idx = DW'(i);
      end
   end

   // Next-state and datapath: accept a job, then one reduction step per RUN cycle.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      dreg_d   = dreg_q;
      deg_d    = deg_q;
      k_d      = k_q;
      quot_d   = quot_q;
      remain_d = remain_q;
      dbz_d    = dbz_q;
      shamt    = k_q - KW'(deg_q);
      dext     = {{(N - 1){1'b0}}, dreg_q};
      rem_step = rem_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               rem_d    = bus.dividend;
               dreg_d   = bus.divisor;
               deg_d    = msb_idx;
               k_d      = KW'(2 * N - 2);
               quot_d   = '0;
               remain_d = '0;
               dbz_d    = (bus.divisor == '0);
               state_d  = (bus.divisor == '0) ? StDone : StRun;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            // Cancel the leading term at x^k by the divisor aligned to that degree.
            if (k_q >= KW'(deg_q) && rem_q[k_q]) begin
               rem_step      = rem_q ^ (dext << shamt);
               quot_d[shamt] = 1'b1;
            end
            rem_d = rem_step;
            if (k_q == '0) begin
               // All terms of degree >= deg(divisor) are now zero.
               remain_d = rem_step[N-2:0];
               state_d  = StDone;
            end else begin
               k_d = k_q - KW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and working registers; asynchronous reset discards any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         dreg_q   <= '0;
         deg_q    <= '0;
         k_q      <= '0;
         quot_q   <= '0;
         remain_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         dreg_q   <= dreg_d;
         deg_q    <= deg_d;
         k_q      <= k_d;
         quot_q   <= quot_d;
         remain_q <= remain_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == StRun);
   assign bus.done        = (state_q == StDone);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = remain_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Self-checking bench for gf2_poly_divider: directed vector table, control corner cases,
// and random round trips through a carry-less multiply reference.
module tb_gf2_poly_divider;

   localparam int unsigned N = 16;
   localparam int unsigned W = 2 * N - 1;

   logic clk;
   logic rst_n;

   gf2_poly_divider_if #(.N(N)) bus ();

   gf2_poly_divider #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   typedef struct {
      logic [W-1:0] dvd;
      logic [N-1:0] dvs;
      logic [W-1:0] q;
      logic [N-2:0] r;
      logic         z;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference product: sum (XOR) of a shifted by each set bit of b.
   function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [W-1:0] p;
      p = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (b[i]) p = p ^ (W'(a) << i);
      end
      return p;
   endfunction

   function automatic int degree(input logic [N-1:0] b);
      int d;
      d = 0;
      for (int i = 0; i < int'(N); i++) begin
         if (b[i]) d = i;
      end
      return d;
   endfunction

   // Runs one job; scrambles the inputs while it is in flight and optionally pulses start.
   task automatic do_job(input logic [W-1:0] dvd, input logic [N-1:0] dvs, input int pulse_at,
                         output int lat, output logic [W-1:0] q, output logic [N-2:0] r,
                         output logic z, output logic busy_ok);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 1;
      busy_ok   = 1'b1;
      while (!bus.done && lat < 100) begin
         if (!bus.busy) busy_ok = 1'b0;
         bus.dividend = W'($urandom);
         bus.divisor  = N'($urandom);
         bus.start    = (lat == pulse_at);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      if (bus.busy) busy_ok = 1'b0;
      q = bus.quotient;
      r = bus.remainder;
      z = bus.div_by_zero;
   endtask

   initial begin
      int           lat;
      logic [W-1:0] q;
      logic [N-2:0] r;
      logic         z;
      logic         bok;
      logic         seen;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] rr;
      logic [N-1:0] mask;

      n_vec = 0;
      n_err = 0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;

      tbl[0] = '{31'h0000_0005, 16'h0003, 31'h0000_0003, 15'h0000, 1'b0};
      tbl[1] = '{31'h0000_0007, 16'h0003, 31'h0000_0002, 15'h0001, 1'b0};
      tbl[2] = '{31'h7FFF_FFFF, 16'h0001, 31'h7FFF_FFFF, 15'h0000, 1'b0};
      tbl[3] = '{31'h4000_0001, 16'h8000, 31'h0000_8000, 15'h0001, 1'b0};
      tbl[4] = '{31'h1234_5678, 16'h0000, 31'h0000_0000, 15'h0000, 1'b1};
      tbl[5] = '{31'h0000_0000, 16'h1234, 31'h0000_0000, 15'h0000, 1'b0};

      // Reset state
      #1;
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_done", 64'(bus.done), 64'h0);
      check("rst_q", 64'(bus.quotient), 64'h0);
      check("rst_r", 64'(bus.remainder), 64'h0);
      check("rst_dbz", 64'(bus.div_by_zero), 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_job(tbl[i].dvd, tbl[i].dvs, 0, lat, q, r, z, bok);
         check($sformatf("tbl%0d_lat", i), 64'(lat), tbl[i].z ? 64'd1 : 64'(2 * N));
         check($sformatf("tbl%0d_q", i), 64'(q), 64'(tbl[i].q));
         check($sformatf("tbl%0d_r", i), 64'(r), 64'(tbl[i].r));
         check($sformatf("tbl%0d_dbz", i), 64'(z), 64'(tbl[i].z));
         check($sformatf("tbl%0d_busy", i), 64'(bok), 64'h1);
      end

      // start pulsed mid-run is ignored
      do_job(31'h7, 16'h3, 5, lat, q, r, z, bok);
      check("pulse_lat", 64'(lat), 64'(2 * N));
      check("pulse_q", 64'(q), 64'h2);
      check("pulse_r", 64'(r), 64'h1);

      // start held through done: second job accepted in the DONE cycle
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 31'h7;
      bus.divisor  = 16'h3;
      @(negedge clk);
      lat          = 1;
      bus.dividend = 31'h4000_0001;
      bus.divisor  = 16'h8000;
      while (!bus.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("b2b1_lat", 64'(lat), 64'(2 * N));
      check("b2b1_q", 64'(bus.quotient), 64'h2);
      check("b2b1_r", 64'(bus.remainder), 64'h1);
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_done_pulse", 64'(bus.done), 64'h0);
      check("b2b_busy", 64'(bus.busy), 64'h1);
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("b2b2_lat", 64'(lat), 64'(2 * N));
      check("b2b2_q", 64'(bus.quotient), 64'h8000);
      check("b2b2_r", 64'(bus.remainder), 64'h1);

      // Random round trips: dividend = a*b ^ r with deg(r) < deg(b)
      for (int it = 0; it < 1000; it++) begin
         a = N'($urandom);
         do begin
            b = N'($urandom) >> $urandom_range(N - 1);
         end while (b == '0);
         mask = (N'(1) << degree(b)) - N'(1);
         rr   = N'($urandom) & mask;
         do_job(clmul(a, b) ^ W'(rr), b, 0, lat, q, r, z, bok);
         check("rand_q", 64'(q), 64'(a));
         check("rand_r", 64'(r), 64'(rr[N-2:0]));
         if (lat != int'(2 * N) || z !== 1'b0) check("rand_lat_dbz", 64'(lat), 64'(2 * N));
      end

      // Reset at cycle 10 of RUN discards the job
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 31'h7FFF_FFFF;
      bus.divisor  = 16'h0001;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(bus.busy), 64'h0);
      check("midrst_done", 64'(bus.done), 64'h0);
      check("midrst_q", 64'(bus.quotient), 64'h0);
      check("midrst_r", 64'(bus.remainder), 64'h0);
      check("midrst_dbz", 64'(bus.div_by_zero), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("midrst_no_done", 64'(seen), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
